// File: rtl/pixel_feed_ctrl_pkg.sv
// Shared FP32 field constants and sequencer state encoding for the pixel feed path.
// Optional build macro used by dependents: PIXEL_FEED_NORM_EN.
package pixel_feed_ctrl_pkg;

  localparam int unsigned FP32_SIGN_W = 1;
  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_MANT_W = 23;
  localparam int unsigned FP32_BIAS   = 127;
  localparam int unsigned NORM_SHIFT  = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/pixel_feed_ctrl_if.sv
// Pixel RAM read port plus FP32 output stream; master = feed controller side.
interface pixel_feed_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned CH     = 3
);
  localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_ch, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_ch, out_last,
    output out_ready
  );
endinterface

// File: rtl/pixel_feed_ctrl_u8_to_fp32.sv
// Exact combinational unsigned-byte to IEEE-754 single conversion.
// PIXEL_FEED_NORM_EN: scale result by 1/256 via the exponent bias only.
module u8_to_fp32
  import pixel_feed_ctrl_pkg::*;
(
  input  logic [7:0]  v,
  output logic [31:0] f
);
`ifdef PIXEL_FEED_NORM_EN
  localparam int unsigned EXP_BIAS = FP32_BIAS - NORM_SHIFT;
`else
  localparam int unsigned EXP_BIAS = FP32_BIAS;
`endif

  logic [2:0]             msb;
  logic [FP32_EXP_W-1:0]  exp_f;
  logic [FP32_MANT_W-1:0] mant;

  always_comb begin
    msb = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) msb = i[2:0];
    end
    // Left-justify under the hidden bit; the leading one falls off the top.
    mant  = FP32_MANT_W'({23'd0, v} << (5'd23 - {2'b00, msb}));
    exp_f = FP32_EXP_W'(EXP_BIAS + 32'(msb));
    f     = '0;
    if (v != 8'd0) f = {FP32_SIGN_W'(0), exp_f, mant};
  end

endmodule

// File: rtl/pixel_feed_ctrl.sv
// Streams one HWC byte image from pixel RAM as FP32 with channel/last tags.
// PIXEL_FEED_NORM_EN (in u8_to_fp32) selects v/256 output scaling.
module pixel_feed_ctrl
  import pixel_feed_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W      = 224,
  parameter int unsigned IMG_H      = 224,
  parameter int unsigned CH         = 3,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  pixel_feed_if.master      bus
);
  localparam int unsigned N     = IMG_W * IMG_H * CH;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CH_W-1:0]   issue_ch_q, issue_ch_d;
  logic              inflight_q, inflight_d;
  logic [CH_W-1:0]   tag_ch_q, tag_ch_d;
  logic              tag_last_q, tag_last_d;
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic [31:0]       fifo_data_d [FIFO_DEPTH];
  logic [CH_W-1:0]   fifo_ch_q   [FIFO_DEPTH];
  logic [CH_W-1:0]   fifo_ch_d   [FIFO_DEPTH];
  logic              fifo_last_q [FIFO_DEPTH];
  logic              fifo_last_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;

  logic [31:0] conv_data;
  logic        rd_en, push, pop;

  u8_to_fp32 u_conv (
    .v (bus.mem_rd_data),
    .f (conv_data)
  );

  assign pop  = (count_q != '0) && bus.out_ready;
  assign push = inflight_q;
  // A slot freed by this cycle's pop is creditable, giving one read per cycle at depth 2.
  assign rd_en = (state_q == FETCH) &&
                 ((32'(count_q) + 32'(inflight_q) - 32'(pop)) < FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    issue_ch_d  = issue_ch_q;
    inflight_d  = rd_en;
    tag_ch_d    = issue_ch_q;
    tag_last_d  = (issue_cnt_q == LAST_IDX);
    fifo_data_d = fifo_data_q;
    fifo_ch_d   = fifo_ch_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + OCC_W'(push) - OCC_W'(pop);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          base_d      = base_addr;
          issue_cnt_d = '0;
          issue_ch_d  = '0;
        end
      end
      FETCH: begin
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          issue_ch_d  = (issue_ch_q == LAST_CH) ? '0 : issue_ch_q + CH_W'(1);
          if (issue_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = conv_data;
      fifo_ch_d[wr_ptr_q]   = tag_ch_q;
      fifo_last_d[wr_ptr_q] = tag_last_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      issue_ch_q  <= '0;
      inflight_q  <= 1'b0;
      tag_ch_q    <= '0;
      tag_last_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_ch_q[i]   <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      issue_ch_q  <= issue_ch_d;
      inflight_q  <= inflight_d;
      tag_ch_q    <= tag_ch_d;
      tag_last_q  <= tag_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_ch_q   <= fifo_ch_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? base_q + ADDR_W'(issue_cnt_q) : '0;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_ch    = fifo_ch_q[rd_ptr_q];
  assign bus.out_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_pixel_feed_ctrl.sv
// Directed bench for pixel_feed_ctrl on a 2x2x3 frame; honours PIXEL_FEED_NORM_EN.
module tb_pixel_feed_ctrl;
  localparam int unsigned IMG_W = 2, IMG_H = 2, CH = 3, ADDR_W = 18, FIFO_DEPTH = 2;
  localparam int N = 12;

  localparam logic [7:0] BYTES [12] = '{8'd0, 8'd1, 8'd3, 8'd128, 8'd255, 8'd7,
                                        8'd2, 8'd4, 8'd16, 8'd64, 8'd200, 8'd9};
`ifdef PIXEL_FEED_NORM_EN
  localparam logic [31:0] EXP_F [12] = '{32'h00000000, 32'h3B800000, 32'h3C400000,
    32'h3F000000, 32'h3F7F0000, 32'h3CE00000, 32'h3C000000, 32'h3C800000,
    32'h3D800000, 32'h3E800000, 32'h3F480000, 32'h3D100000};
`else
  localparam logic [31:0] EXP_F [12] = '{32'h00000000, 32'h3F800000, 32'h40400000,
    32'h43000000, 32'h437F0000, 32'h40E00000, 32'h40000000, 32'h40800000,
    32'h41800000, 32'h42800000, 32'h43480000, 32'h41100000};
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done;
  logic [7:0]        ram [0:1023];
  int                n_cmp = 0;
  int                n_err = 0;

  pixel_feed_if #(.ADDR_W(ADDR_W), .CH(CH)) bus ();

  pixel_feed_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr[9:0]];
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0)
      $display("FAIL reset_ctl: got %b expected 00000",
               {busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last});
    n_cmp++;
    if (bus.mem_addr !== '0) $display("FAIL reset_addr: got %h expected 0", bus.mem_addr);
    n_cmp++;
    if (bus.out_data !== 32'h0 || bus.out_ch !== 2'd0)
      $display("FAIL reset_data: got %h/%0d expected 0/0", bus.out_data, bus.out_ch);
    n_err += ({busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0) ? 1 : 0;
    n_err += (bus.mem_addr !== '0) ? 1 : 0;
    n_err += (bus.out_data !== 32'h0 || bus.out_ch !== 2'd0) ? 1 : 0;
    reset = 1'b0;
  endtask

  // mode 0: ready high, 1: ready toggles, 2: 20-cycle stall, 3: start re-pulsed while busy
  task automatic test_frame(input int mode, input string tag);
    int cyc, idx, issued, last_hs, max_out;
    bit done_seen, stalled;
    logic [31:0] held_d;
    logic [1:0]  held_ch;
    logic        held_last;
    idx = 0; issued = 0; last_hs = -10; max_out = 0; done_seen = 0; stalled = 0;
    held_d = '0; held_ch = '0; held_last = 1'b0;
    @(negedge clk);
    base_addr = 18'h100; start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!done_seen && cyc < 300) begin
      case (mode)
        1:       bus.out_ready = (cyc % 2 == 1);
        2:       bus.out_ready = !(cyc >= 6 && cyc < 26);
        default: bus.out_ready = 1'b1;
      endcase
      if (mode == 3) begin
        start     = (cyc == 5);
        base_addr = (cyc == 5) ? 18'h200 : 18'h100;
      end
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++; $display("FAIL %s busy cyc%0d: got %b expected 1", tag, cyc, busy);
      end
      if (stalled) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held_d ||
            bus.out_ch !== held_ch || bus.out_last !== held_last) begin
          n_err++;
          $display("FAIL %s hold cyc%0d: got v%b %h/%0d/%b expected v1 %h/%0d/%b", tag, cyc,
                   bus.out_valid, bus.out_data, bus.out_ch, bus.out_last, held_d, held_ch, held_last);
        end
      end
      if (bus.mem_rd_en) begin
        n_cmp++;
        if (bus.mem_addr !== ADDR_W'(32'h100 + issued)) begin
          n_err++;
          $display("FAIL %s addr[%0d]: got %h expected %h", tag, issued, bus.mem_addr,
                   ADDR_W'(32'h100 + issued));
        end
        n_cmp++;
        if ((issued - idx) >= FIFO_DEPTH && !(bus.out_valid && bus.out_ready)) begin
          n_err++;
          $display("FAIL %s credit cyc%0d: got read with %0d outstanding expected none",
                   tag, cyc, issued - idx);
        end
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (idx >= N) begin
          n_err++; $display("FAIL %s extra: got element %0d expected at most %0d", tag, idx, N);
        end else if (bus.out_data !== EXP_F[idx] || bus.out_ch !== 2'(idx % CH) ||
                     bus.out_last !== (idx == N - 1)) begin
          n_err++;
          $display("FAIL %s elem[%0d]: got %h/%0d/%b expected %h/%0d/%b", tag, idx,
                   bus.out_data, bus.out_ch, bus.out_last, EXP_F[idx], idx % CH, idx == N - 1);
        end
        if (mode == 0 || mode == 3) begin
          n_cmp++;
          if (cyc != 3 + idx) begin
            n_err++; $display("FAIL %s timing[%0d]: got cyc %0d expected %0d", tag, idx, cyc, 3 + idx);
          end
        end
        last_hs = cyc;
        idx++;
      end
      if (issued - idx > max_out) max_out = issued - idx;
      stalled   = bus.out_valid && !bus.out_ready;
      held_d    = bus.out_data;
      held_ch   = bus.out_ch;
      held_last = bus.out_last;
      if (done) begin
        done_seen = 1;
        n_cmp++;
        if (idx != N || cyc != last_hs + 1) begin
          n_err++;
          $display("FAIL %s done: got cyc %0d after %0d elems expected cyc %0d after %0d",
                   tag, cyc, idx, last_hs + 1, N);
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (!done_seen) begin
      n_err++; $display("FAIL %s timeout: got no done expected done pulse", tag);
    end
    n_cmp++;
    if (idx != N || issued != N) begin
      n_err++; $display("FAIL %s count: got %0d out %0d reads expected %0d", tag, idx, issued, N);
    end
    n_cmp++;
    if (max_out > FIFO_DEPTH) begin
      n_err++; $display("FAIL %s outstanding: got %0d expected <= %0d", tag, max_out, FIFO_DEPTH);
    end
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL %s idle: got busy %b done %b expected 0 0", tag, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int hs, cyc;
    hs = 0; cyc = 0;
    @(negedge clk);
    base_addr = 18'h100; start = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (hs < 5 && cyc < 50) begin
      #1;
      if (bus.out_valid && bus.out_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (hs != 5) begin
      n_err++; $display("FAIL rst_mid reach: got %0d elems expected 5", hs);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last} !== 5'b0 ||
        bus.out_data !== 32'h0 || bus.out_ch !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid outputs: got ctl %b data %h ch %0d expected 00000 0 0",
               {busy, done, bus.mem_rd_en, bus.out_valid, bus.out_last}, bus.out_data, bus.out_ch);
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rst_mid quiet: got busy %b done %b expected 0 0", busy, done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'd0;
    for (int k = 0; k < N; k++) begin
      ram[256 + k] = BYTES[k];
      ram[512 + k] = 8'hAA;
    end
    test_reset();
    test_frame(0, "stream");
    test_frame(1, "toggle");
    test_frame(2, "stall");
    test_frame(3, "restart");
    test_reset_mid();
    test_frame(0, "replay");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
